// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DATAPATH_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DATAPATH_WIDTH);

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed mult (radix-2 Booth) / div (restoring) unit with HI/LO result registers.
// Optional MULT_DIV_DIVZERO_EXC_EN: divide-by-zero aborts at start and pulses DivZero.
//
// state   | meaning
// IDLE    | waiting for Start; HI/LO hold last result
// MULT    | one Booth step per cycle, WIDTH steps
// DIV     | one restoring quotient bit per cycle, WIDTH steps
// FIX     | sign correction, write HI/LO, pulse Done
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH + 1;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] d_r;
    logic             b_neg;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH:0]   hi_ext;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             last_step;

    sign_fix #(.WIDTH(WIDTH)) u_a_mag (.value(A), .negate(A[WIDTH-1]), .result(a_mag));
    sign_fix #(.WIDTH(WIDTH)) u_b_mag (.value(B), .negate(B[WIDTH-1]), .result(b_mag));
    sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
        .value (prod[WIDTH:1]),
        .negate(a_r[WIDTH-1] ^ b_neg),
        .result(quo_fix)
    );
    sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
        .value (prod[PW-1:WIDTH+1]),
        .negate(a_r[WIDTH-1]),
        .result(rem_fix)
    );

    // Booth accumulates one bit wider so MIN_INT multiplicands shift in the true sign.
    always_comb begin
        hi_ext    = {prod[PW-1], prod[PW-1:WIDTH+1]};
        m_ext     = {a_r[WIDTH-1], a_r};
        booth_sum = hi_ext;
        case (prod[1:0])
            2'b01:   booth_sum = hi_ext + m_ext;
            2'b10:   booth_sum = hi_ext - m_ext;
            default: booth_sum = hi_ext;
        endcase
        div_shift = {prod[PW-1:WIDTH+1], prod[WIDTH]};
        div_diff  = div_shift - {1'b0, d_r};
    end

    assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef MULT_DIV_DIVZERO_EXC_EN
    logic div_zero_r;
    assign DivZero = div_zero_r;
`else
    assign DivZero = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_r   <= OP_MULT;
            a_r    <= '0;
            d_r    <= '0;
            b_neg  <= 1'b0;
            prod   <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EXC_EN
            div_zero_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EXC_EN
            div_zero_r <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (Start) begin
`ifdef MULT_DIV_DIVZERO_EXC_EN
                        if (Op == OP_DIV && B == '0) begin
                            div_zero_r <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            a_r   <= A;
                            d_r   <= b_mag;
                            b_neg <= B[WIDTH-1];
                            op_r  <= Op;
                            cnt   <= '0;
                            prod  <= (Op == OP_MULT) ? {{WIDTH{1'b0}}, B, 1'b0}
                                                     : {{WIDTH{1'b0}}, a_mag, 1'b0};
                            state <= (Op == OP_MULT) ? ST_MULT : ST_DIV;
                        end
                    end
                end
                ST_MULT: begin
                    prod <= {booth_sum, prod[WIDTH:1]};
                    cnt  <= cnt + CW'(1);
                    if (last_step) state <= ST_FIX;
                end
                ST_DIV: begin
                    if (!div_diff[WIDTH])
                        prod <= {div_diff[WIDTH-1:0], prod[WIDTH-1:1], 1'b1, 1'b0};
                    else
                        prod <= {div_shift[WIDTH-1:0], prod[WIDTH-1:1], 1'b0, 1'b0};
                    cnt <= cnt + CW'(1);
                    if (last_step) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (op_r == OP_MULT) begin
                        hi_r <= prod[PW-1:WIDTH+1];
                        lo_r <= prod[WIDTH:1];
                    end else if (d_r == '0) begin
                        hi_r <= a_r;
                        lo_r <= '1;
                    end else begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end
                    done_r <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy = (state != ST_IDLE);
    assign Done = done_r;
    assign Hi   = hi_r;
    assign Lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (32-bit), honours MULT_DIV_DIVZERO_EXC_EN.
module tb_mult_div_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        DivZero;

    int n_checks = 0;
    int n_fail   = 0;

    int          busy_cnt;
    bit          got_done;
    bit          dz_seen;
    logic [31:0] hi_first;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivZero(DivZero)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives Start there and follows the op until Done or timeout.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input int repulse_at);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
        busy_cnt = 0; got_done = 0; dz_seen = 0; hi_first = Hi;
        for (int i = 0; i < 100 && !got_done; i++) begin
            if (Busy) busy_cnt++;
            if (DivZero) dz_seen = 1;
            if (Done) got_done = 1;
            else begin
                if (repulse_at != 0 && i == repulse_at) begin
                    Start = 1'b1; Op = 1'b1; A = 32'd9; B = 32'd3;
                end else begin
                    Start = 1'b0;
                end
                @(negedge Clk);
            end
        end
        Start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 1'b0; A = '0; B = '0;
        #1 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        check("rst_divzero", {31'd0, DivZero}, 32'd0);
        Reset = 1'b1;

        // 7 * -3
        @(negedge Clk);
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0);
        check("m1_done", {31'd0, got_done}, 32'd1);
        check("m1_busy_cycles", busy_cnt, 32'd33);
        check("m1_hi", Hi, 32'hFFFF_FFFF);
        check("m1_lo", Lo, 32'hFFFF_FFEB);
        @(negedge Clk);
        check("m1_done_clear", {31'd0, Done}, 32'd0);
        check("m1_lo_hold", Lo, 32'hFFFF_FFEB);

        // MIN_INT * MIN_INT, then back-to-back 0 * 5 started in the Done cycle
        @(negedge Clk);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        check("m2_done", {31'd0, got_done}, 32'd1);
        check("m2_hi", Hi, 32'h4000_0000);
        check("m2_lo", Lo, 32'h0000_0000);
        run_op(1'b0, 32'd0, 32'd5, 0);
        check("b2b_hi_held", hi_first, 32'h4000_0000);
        check("b2b_done", {31'd0, got_done}, 32'd1);
        check("b2b_busy_cycles", busy_cnt, 32'd33);
        check("b2b_hi", Hi, 32'd0);
        check("b2b_lo", Lo, 32'd0);

        // -7 / 2
        @(negedge Clk);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        check("d1_done", {31'd0, got_done}, 32'd1);
        check("d1_busy_cycles", busy_cnt, 32'd33);
        check("d1_lo", Lo, 32'hFFFF_FFFD);
        check("d1_hi", Hi, 32'hFFFF_FFFF);

        // MIN_INT / -1
        @(negedge Clk);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("d2_done", {31'd0, got_done}, 32'd1);
        check("d2_lo", Lo, 32'h8000_0000);
        check("d2_hi", Hi, 32'h0000_0000);
        check("d2_divzero", {31'd0, dz_seen}, 32'd0);

        // 5 / 0
        @(negedge Clk);
`ifdef MULT_DIV_DIVZERO_EXC_EN
        Start = 1'b1; Op = 1'b1; A = 32'd5; B = 32'd0;
        @(negedge Clk);
        Start = 1'b0;
        check("dz_pulse", {31'd0, DivZero}, 32'd1);
        check("dz_busy", {31'd0, Busy}, 32'd0);
        check("dz_no_done", {31'd0, Done}, 32'd0);
        @(negedge Clk);
        check("dz_pulse_end", {31'd0, DivZero}, 32'd0);
        check("dz_no_done2", {31'd0, Done}, 32'd0);
        check("dz_hi_kept", Hi, 32'h0000_0000);
        check("dz_lo_kept", Lo, 32'h8000_0000);
`else
        run_op(1'b1, 32'd5, 32'd0, 0);
        check("dz_done", {31'd0, got_done}, 32'd1);
        check("dz_busy_cycles", busy_cnt, 32'd33);
        check("dz_hi", Hi, 32'd5);
        check("dz_lo", Lo, 32'hFFFF_FFFF);
        check("dz_flag", {31'd0, dz_seen}, 32'd0);
`endif

        // 100 * -2 with a stray Start (div 9/3) mid-operation
        @(negedge Clk);
        run_op(1'b0, 32'd100, 32'hFFFF_FFFE, 5);
        check("rp_done", {31'd0, got_done}, 32'd1);
        check("rp_busy_cycles", busy_cnt, 32'd33);
        check("rp_hi", Hi, 32'hFFFF_FFFF);
        check("rp_lo", Lo, 32'hFFFF_FF38);

        // Reset in the middle of 100 / 7
        @(negedge Clk);
        Start = 1'b1; Op = 1'b1; A = 32'd100; B = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        check("ra_busy_before", {31'd0, Busy}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("ra_busy", {31'd0, Busy}, 32'd0);
        check("ra_done", {31'd0, Done}, 32'd0);
        check("ra_hi", Hi, 32'd0);
        check("ra_lo", Lo, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("ra_idle_after", {31'd0, Busy}, 32'd0);
        run_op(1'b0, 32'd3, 32'd4, 0);
        check("ra_m_done", {31'd0, got_done}, 32'd1);
        check("ra_m_busy_cycles", busy_cnt, 32'd33);
        check("ra_m_lo", Lo, 32'd12);
        check("ra_m_hi", Hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
